// File: rtl/divu_pkg.sv
// -----------------------------------------------------------------------------
// divu_pkg -- shared definitions for the unsigned restoring divider.
//
// Contents:
//   DIVU_WIDTH       default operand / quotient / remainder width
//   divu_state_e     FSM state encoding (IDLE, RUN, DONE)
//   divu_cnt_width() width of the iteration counter for a given operand width
//   DIVU_CNT_W       counter width for the default operand width
// -----------------------------------------------------------------------------
package divu_pkg;

    localparam int DIVU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } divu_state_e;

    // The counter is loaded with the operand width itself, so it needs
    // one bit more than clog2(width) to represent that value.
    function automatic int divu_cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int DIVU_CNT_W = divu_cnt_width(DIVU_WIDTH);

endpackage : divu_pkg

// File: rtl/divu.sv
// -----------------------------------------------------------------------------
// divu -- multi-cycle unsigned restoring divider.
//
// A division is started by a one-cycle start request while the divider is in
// IDLE or DONE. The divider then runs one restoring step per clock for WIDTH
// cycles and pulses done for one cycle with the result on q / r.
//
// Ports:
//   clk       in   1      clock, all state changes on the rising edge
//   reset     in   1      synchronous active-high reset
//   start     in   1      request a new division (ignored while busy)
//   dividend  in   WIDTH  unsigned dividend, sampled when start is accepted
//   divisor   in   WIDTH  unsigned divisor, sampled when start is accepted
//   busy      out  1      high while the divider is iterating (state RUN)
//   done      out  1      one-cycle pulse, q / r / div_zero valid from here
//   q         out  WIDTH  quotient of the last completed division
//   r         out  WIDTH  remainder of the last completed division
//   div_zero  out  1      last completed division had a zero divisor
// -----------------------------------------------------------------------------
module divu
    import divu_pkg::*;
#(
    parameter int WIDTH = DIVU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);

    localparam int              CNT_W    = divu_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Control state
    divu_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;

    // Datapath: partial remainder, quotient shift register (which starts out
    // holding the dividend), and the captured divisor.
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic             dz_pend_q;

    // Registered outputs
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             dz_q;

    // One restoring step
    logic [WIDTH:0]   shifted_d;
    logic [WIDTH:0]   trial_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    // The partial remainder is always below the divisor (or, for a zero
    // divisor, below 2^k after k steps), so after the shift it fits in
    // WIDTH+1 bits and a negative trial difference always shows up in bit
    // WIDTH. A single WIDTH+1-bit subtractor is therefore enough, and any
    // kept value (difference or restored remainder) fits back into WIDTH bits.
    always_comb begin
        shifted_d = {rem_q, quo_q[WIDTH-1]};
        trial_d   = shifted_d - {1'b0, dsr_q};
        if (!trial_d[WIDTH]) begin
            rem_d = trial_d[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shifted_d[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            dz_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            dz_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        rem_q     <= '0;
                        quo_q     <= dividend;
                        dsr_q     <= divisor;
                        dz_pend_q <= (divisor == '0);
                        cnt_q     <= CNT_LOAD;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end else begin
                        state_q   <= IDLE;
                    end
                end

                RUN: begin
                    // start is deliberately not looked at here: requests
                    // during a division are dropped.
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        // Final step: publish the result straight from the
                        // step logic so q/r change only on entry to DONE.
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        q_q     <= quo_d;
                        r_q     <= rem_d;
                        dz_q    <= dz_pend_q;
                        state_q <= DONE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign q        = q_q;
    assign r        = r_q;
    assign div_zero = dz_q;

endmodule : divu

// File: tb/tb_divu.sv
// -----------------------------------------------------------------------------
// tb_divu -- self-checking bench for divu (WIDTH = 32).
// Expected results are pushed to a scoreboard queue when a division is
// started and popped when the divider reports done.
// -----------------------------------------------------------------------------
module tb_divu;

    localparam int W       = 32;
    localparam int LAT     = W + 1;   // edges from accepting edge to done
    localparam int TIMEOUT = 100;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_zero;

    exp_t sb[$];
    int   total;
    int   bad;

    divu #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one start request and waits for done. Optionally pulses start
    // again (with operands 9/2) on edge number inject_at while running.
    // Operands are scrambled after acceptance to show they are don't-care.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int inject_at,
                           output logic [W-1:0] oq, output logic [W-1:0] orr,
                           output logic odz, output int edges);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        edges    = TIMEOUT;
        oq       = '0;
        orr      = '0;
        odz      = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == inject_at) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd2;
            end else begin
                start    = 1'b0;
                dividend = $urandom;
                divisor  = $urandom;
            end
            if (done) begin
                oq    = q;
                orr   = r;
                odz   = div_zero;
                edges = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset    = 1'b1;
        start    = 1'b1;      // reset must win over start
        dividend = 32'd100;
        divisor  = 32'd7;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: busy=%b done=%b, required busy=0 done=0", busy, done);
        end
        total++;
        if (q !== '0 || r !== '0 || div_zero !== 1'b0) begin
            bad++;
            $display("FAIL reset_data: q=%h r=%h dz=%b, required all zero", q, r, div_zero);
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b after release, required 0", busy);
        end
        $display("reset: busy=%b done=%b q=%h r=%h dz=%b", busy, done, q, r, div_zero);
    endtask

    task automatic test_divide;
        logic [W-1:0] oq, orr;
        logic         odz;
        int           edges;
        exp_t         e;
        exp_t         tbl_e[5];
        logic [W-1:0] tbl_a[5];
        logic [W-1:0] tbl_b[5];
        tbl_a[0] = 32'd100;      tbl_b[0] = 32'd7;
        tbl_e[0] = '{q: 32'd14, r: 32'd2, dz: 1'b0};
        tbl_a[1] = 32'hE6104084; tbl_b[1] = 32'hE65460A4;
        tbl_e[1] = '{q: 32'h00000000, r: 32'hE6104084, dz: 1'b0};
        tbl_a[2] = 32'hFFFFFFFF; tbl_b[2] = 32'h00010000;
        tbl_e[2] = '{q: 32'h0000FFFF, r: 32'h0000FFFF, dz: 1'b0};
        tbl_a[3] = 32'hFFFFFFFF; tbl_b[3] = 32'd1;
        tbl_e[3] = '{q: 32'hFFFFFFFF, r: 32'd0, dz: 1'b0};
        tbl_a[4] = 32'h12345678; tbl_b[4] = 32'd0;
        tbl_e[4] = '{q: 32'hFFFFFFFF, r: 32'h12345678, dz: 1'b1};
        for (int t = 0; t < 5; t++) begin
            sb.push_back(tbl_e[t]);
            run_div(tbl_a[t], tbl_b[t], -1, oq, orr, odz, edges);
            e = sb.pop_front();
            total++;
            if (edges !== LAT) begin
                bad++;
                $display("FAIL div%0d_latency: edges=%0d, required %0d", t, edges, LAT);
            end
            total++;
            if (oq !== e.q || orr !== e.r || odz !== e.dz) begin
                bad++;
                $display("FAIL div%0d_result: q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
                         t, oq, orr, odz, e.q, e.r, e.dz);
            end
            // done is a single-cycle pulse and the result holds afterwards
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || q !== e.q || r !== e.r || div_zero !== e.dz) begin
                bad++;
                $display("FAIL div%0d_hold: done=%b busy=%b q=%h r=%h dz=%b, required done=0 busy=0 q=%h r=%h dz=%b",
                         t, done, busy, q, r, div_zero, e.q, e.r, e.dz);
            end
            $display("div %h / %h -> q=%h r=%h dz=%b edges=%0d", tbl_a[t], tbl_b[t], oq, orr, odz, edges);
        end
    endtask

    task automatic test_ignore_start;
        logic [W-1:0] oq, orr;
        logic         odz;
        int           edges;
        exp_t         e;
        sb.push_back('{q: 32'd10, r: 32'd0, dz: 1'b0});
        run_div(32'd50, 32'd5, 5, oq, orr, odz, edges);
        e = sb.pop_front();
        total++;
        if (edges !== LAT) begin
            bad++;
            $display("FAIL ignore_latency: edges=%0d, required %0d", edges, LAT);
        end
        total++;
        if (oq !== e.q || orr !== e.r || odz !== e.dz) begin
            bad++;
            $display("FAIL ignore_result: q=%0d r=%0d dz=%b, required q=%0d r=%0d dz=%b",
                     oq, orr, odz, e.q, e.r, e.dz);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_idle: busy=%b after done, required 0", busy);
        end
        $display("div 50 / 5 with start during RUN -> q=%0d r=%0d edges=%0d", oq, orr, edges);
    endtask

    task automatic test_reset_abort;
        logic [W-1:0] oq, orr;
        logic         odz;
        int           edges;
        int           pulses;
        exp_t         e;
        sb.push_back('{q: 32'd333, r: 32'd1, dz: 1'b0});
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(negedge clk);       // accepting edge passed
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;         // takes effect on the 10th RUN edge
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_front()); // aborted division produces no result
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== '0 || r !== '0) begin
            bad++;
            $display("FAIL abort_state: busy=%b done=%b q=%0d r=%0d, required all zero", busy, done, q, r);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL abort_no_done: done pulses=%0d, required 0", pulses);
        end
        $display("abort 1000 / 3 by reset: busy=%b q=%0d r=%0d pulses=%0d", busy, q, r, pulses);
        sb.push_back('{q: 32'd333, r: 32'd1, dz: 1'b0});
        run_div(32'd1000, 32'd3, -1, oq, orr, odz, edges);
        e = sb.pop_front();
        total++;
        if (edges !== LAT || oq !== e.q || orr !== e.r || odz !== e.dz) begin
            bad++;
            $display("FAIL abort_restart: edges=%0d q=%0d r=%0d dz=%b, required edges=%0d q=%0d r=%0d dz=%b",
                     edges, oq, orr, odz, LAT, e.q, e.r, e.dz);
        end
        $display("div 1000 / 3 after abort -> q=%0d r=%0d edges=%0d", oq, orr, edges);
    endtask

    task automatic test_back_to_back;
        int   edges;
        exp_t e;
        sb.push_back('{q: 32'd9, r: 32'd5, dz: 1'b0});
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd8;
        edges    = TIMEOUT;
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                edges = i;
                break;
            end
        end
        e = sb.pop_front();
        total++;
        if (edges !== LAT || q !== e.q || r !== e.r) begin
            bad++;
            $display("FAIL b2b_first: edges=%0d q=%0d r=%0d, required edges=%0d q=%0d r=%0d",
                     edges, q, r, LAT, e.q, e.r);
        end
        $display("b2b div 77 / 8 -> q=%0d r=%0d edges=%0d", q, r, edges);
        // Hold start in the DONE cycle: next division must begin immediately
        start    = 1'b1;
        dividend = 32'd200;
        divisor  = 32'd9;
        sb.push_back('{q: 32'd22, r: 32'd2, dz: 1'b0});
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_no_idle: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        edges = TIMEOUT;
        for (int i = 2; i <= TIMEOUT; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                edges = i;
                break;
            end
        end
        e = sb.pop_front();
        total++;
        if (edges !== LAT || q !== e.q || r !== e.r || div_zero !== e.dz) begin
            bad++;
            $display("FAIL b2b_second: edges=%0d q=%0d r=%0d dz=%b, required edges=%0d q=%0d r=%0d dz=%b",
                     edges, q, r, div_zero, LAT, e.q, e.r, e.dz);
        end
        $display("b2b div 200 / 9 -> q=%0d r=%0d edges=%0d", q, r, edges);
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, oq, orr;
        logic         odz;
        int           edges;
        exp_t         e;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: a = '1;
                2: b = '1;
                3: b = W'($urandom_range(1, 255));
                4: a = '0;
                5: begin a = '1; b = '0; end
                6: a = W'($urandom_range(0, 1000));
                default: ;
            endcase
            if (b == '0) e = '{q: '1, r: a, dz: 1'b1};
            else         e = '{q: a / b, r: a % b, dz: 1'b0};
            sb.push_back(e);
            run_div(a, b, -1, oq, orr, odz, edges);
            e = sb.pop_front();
            total++;
            if (edges !== LAT || oq !== e.q || orr !== e.r || odz !== e.dz) begin
                bad++;
                $display("FAIL rand%0d: %h/%h edges=%0d q=%h r=%h dz=%b, required edges=%0d q=%h r=%h dz=%b",
                         n, a, b, edges, oq, orr, odz, LAT, e.q, e.r, e.dz);
            end
            $display("rand%0d %h / %h -> q=%h r=%h dz=%b", n, a, b, oq, orr, odz);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_divide();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_divu
